// File: rtl/mp64_pll_supervisor.sv
// Multi-channel PLL supervisor: pulses each PLL's reset, filters its lock,
// and releases the derived-domain resets in channel order.
// Latency: lock seen 2 sync cycles + FILTER_CYC after rising; domain release
// RELEASE_GAP cycles after its release condition; all_ready is one more
// register stage. No backpressure: status inputs, level outputs only.
//
// Ports
//   clk_in          free-running reference clock, clocks all logic
//   rst_n           synchronous active-low reset
//   pll_locked_raw  per-channel raw PLL lock (asynchronous, synchronized here)
//   ch_en           per-channel enable; low forces the channel to OFF
//   fault_clr       per-channel single-cycle pulse that leaves FAULT
//   pll_rst         active-high reset to each PLL primitive
//   locked_filt     filtered lock (high while the channel is LOCKED)
//   dom_rst_n       active-low reset for each derived clock domain
//   fault           retries exhausted for the channel
//   loss_sticky     lock was lost after being declared; cleared by rst_n only
//   all_ready       registered: every enabled channel has its domain released

module mp64_pll_supervisor #(
  parameter int NUM_CH       = 2,
  parameter int RST_CYC      = 16,
  parameter int FILTER_CYC   = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int RELEASE_GAP  = 64
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pll_locked_raw,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] fault_clr,
  output logic [NUM_CH-1:0] pll_rst,
  output logic [NUM_CH-1:0] locked_filt,
  output logic [NUM_CH-1:0] dom_rst_n,
  output logic [NUM_CH-1:0] fault,
  output logic [NUM_CH-1:0] loss_sticky,
  output logic              all_ready
);

  // Every counter is wide enough for its parameter's full value, so none wraps.
  localparam int RST_W = $clog2(RST_CYC + 1);
  localparam int FLT_W = $clog2(FILTER_CYC + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int REL_W = $clog2(RELEASE_GAP + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);
  localparam logic [REL_W-1:0] REL_MAX  = REL_W'(RELEASE_GAP);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_RST    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  logic all_ready_q;
  logic all_ready_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

    logic             sync1_q;
    logic             sync2_q;
    logic [2:0]       state_q,    state_d;
    logic [RST_W-1:0] rst_cnt_q,  rst_cnt_d;
    logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic [RTY_W-1:0] retry_q,    retry_d;
    logic             loss_q,     loss_d;
    logic [REL_W-1:0] rel_cnt_q,  rel_cnt_d;
    logic             dom_q,      dom_d;
    logic             lock_s;
    logic             prev_ok;
    logic             rel_cond;

    assign lock_s = sync2_q;

    // Release chains upward: channel i waits for channel i-1's domain,
    // unless channel i-1 is disabled and therefore out of the chain.
    if (i == 0) begin : g_first
      assign prev_ok = 1'b1;
    end else begin : g_chain
      assign prev_ok = dom_rst_n[i-1] | ~ch_en[i-1];
    end

    // Lock / retry state machine.
    always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      filt_cnt_d = filt_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      retry_d    = retry_q;
      loss_d     = loss_q;

      if (!ch_en[i]) begin
        // Disable wins from any state; loss history survives.
        state_d    = ST_OFF;
        rst_cnt_d  = '0;
        filt_cnt_d = '0;
        tmo_cnt_d  = '0;
        retry_d    = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            state_d   = ST_RST;
            rst_cnt_d = '0;
          end

          ST_RST: begin
            if (rst_cnt_q == RST_LAST) begin
              state_d    = ST_WAIT;
              filt_cnt_d = '0;
              tmo_cnt_d  = '0;
            end else begin
              rst_cnt_d = rst_cnt_q + 1'b1;
            end
          end

          ST_WAIT: begin
            // Run-length of synced-high cycles; any low cycle restarts it.
            filt_cnt_d = lock_s ? filt_cnt_q + 1'b1 : '0;
            tmo_cnt_d  = tmo_cnt_q + 1'b1;
            // Lock is tested first so it wins a same-cycle timeout.
            if (lock_s && (filt_cnt_q == FLT_LAST)) begin
              state_d = ST_LOCKED;
            end else if (tmo_cnt_q == TMO_LAST) begin
              retry_d   = retry_q + 1'b1;
              rst_cnt_d = '0;
              state_d   = (retry_q == RTY_LAST) ? ST_FAULT : ST_RST;
            end
          end

          ST_LOCKED: begin
            if (!lock_s) begin
              loss_d    = 1'b1;
              retry_d   = '0;
              rst_cnt_d = '0;
              state_d   = ST_RST;
            end
          end

          ST_FAULT: begin
            if (fault_clr[i]) begin
              retry_d   = '0;
              rst_cnt_d = '0;
              state_d   = ST_RST;
            end
          end

          default: begin
            state_d = ST_OFF;
          end
        endcase
      end
    end

    // Domain release: the condition must hold RELEASE_GAP consecutive cycles;
    // the counter saturates so the domain stays released while it holds.
    assign rel_cond = ch_en[i] & (state_q == ST_LOCKED) & prev_ok;

    always_comb begin
      rel_cnt_d = '0;
      if (rel_cond) begin
        rel_cnt_d = (rel_cnt_q == REL_MAX) ? rel_cnt_q : rel_cnt_q + 1'b1;
      end
      dom_d = rel_cond & (rel_cnt_d == REL_MAX);
    end

    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        state_q    <= ST_OFF;
        rst_cnt_q  <= '0;
        filt_cnt_q <= '0;
        tmo_cnt_q  <= '0;
        retry_q    <= '0;
        loss_q     <= 1'b0;
        rel_cnt_q  <= '0;
        dom_q      <= 1'b0;
      end else begin
        sync1_q    <= pll_locked_raw[i];
        sync2_q    <= sync1_q;
        state_q    <= state_d;
        rst_cnt_q  <= rst_cnt_d;
        filt_cnt_q <= filt_cnt_d;
        tmo_cnt_q  <= tmo_cnt_d;
        retry_q    <= retry_d;
        loss_q     <= loss_d;
        rel_cnt_q  <= rel_cnt_d;
        dom_q      <= dom_d;
      end
    end

    // The PLL is held in reset everywhere except while acquiring or locked.
    assign pll_rst[i]     = (state_q == ST_OFF) | (state_q == ST_RST) |
                            (state_q == ST_FAULT);
    assign locked_filt[i] = (state_q == ST_LOCKED);
    assign fault[i]       = (state_q == ST_FAULT);
    assign loss_sticky[i] = loss_q;
    // Masking with ch_en keeps a disabled domain in reset immediately.
    assign dom_rst_n[i]   = dom_q & ch_en[i];
  end

  assign all_ready_d = (|ch_en) & (&(dom_rst_n | ~ch_en));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= all_ready_d;
    end
  end

  assign all_ready = all_ready_q;

endmodule

// File: doc/mp64_pll_supervisor.md
MP64_PLL_SUPERVISOR -- requirements
Module: mp64_pll_supervisor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of supervised PLL channels (1..8).
REQ-002 SHALL have parameter RST_CYC, default 16: pll_rst pulse length in clk_in cycles (>=1).
REQ-003 SHALL have parameter FILTER_CYC, default 256: number of consecutive synced-lock-high cycles needed to declare lock (>=1).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536: WAIT-state cycles allowed before a retry (>FILTER_CYC).
REQ-005 SHALL have parameter MAX_RETRY, default 3: number of timeouts before FAULT (>=1).
REQ-006 SHALL have parameter RELEASE_GAP, default 64: delay in cycles between lock and per-domain reset release (>=1).
REQ-007 SHALL have port clk_in, input, 1: the single clock (free-running reference clock), used for all logic.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port pll_locked_raw, input, NUM_CH: per-channel raw PLL lock, asynchronous to clk_in.
REQ-010 SHALL have port ch_en, input, NUM_CH: per-channel enable.
REQ-011 SHALL have port fault_clr, input, NUM_CH: per-channel single-cycle pulse that clears FAULT.
REQ-012 SHALL have port pll_rst, output, NUM_CH: active-high reset to each PLL primitive.
REQ-013 SHALL have port locked_filt, output, NUM_CH: filtered lock.
REQ-014 SHALL have port dom_rst_n, output, NUM_CH: active-low reset for each derived clock domain.
REQ-015 SHALL have port fault, output, NUM_CH: retries exhausted.
REQ-016 SHALL have port loss_sticky, output, NUM_CH: lock was lost after being declared; cleared only by rst_n.
REQ-017 SHALL have port all_ready, output, 1: every enabled channel is released.

Function
REQ-018 SHALL pass each pll_locked_raw bit through a 2-flop synchronizer; all decisions use the synced value.
REQ-019 SHALL run one independent FSM per channel with states OFF, RST, WAIT, LOCKED and FAULT.
REQ-020 SHALL, in OFF: drive pll_rst=1; leave OFF for RST when ch_en=1.
REQ-021 SHALL, in RST: drive pll_rst=1 for exactly RST_CYC cycles, then enter WAIT with the filter and timeout counters at 0.
REQ-022 SHALL, in WAIT: drive pll_rst=0; count consecutive synced-lock-high cycles; any low cycle resets this count to 0.
REQ-023 SHALL, in WAIT, enter LOCKED when the filter count reaches FILTER_CYC; locked_filt rises on the entry cycle.
REQ-024 SHALL, in WAIT, on the timeout count reaching LOCK_TIMEOUT: increment retry_cnt; enter FAULT if retry_cnt reaches MAX_RETRY, else enter RST.
REQ-025 SHALL apply lock priority when lock and timeout occur in the same cycle.
REQ-026 SHALL, in LOCKED: on a single synced-lock-low cycle, set loss_sticky, clear locked_filt, zero retry_cnt, and enter RST.
REQ-027 SHALL, in FAULT: drive pll_rst=1 and fault=1; on fault_clr, enter RST with retry_cnt=0 and fault=0.
REQ-028 SHALL force a channel to OFF from any state on ch_en=0, with locked_filt=0 and fault=0; loss_sticky is retained.
REQ-029 SHALL set the release condition for channel i as locked_filt[i]=1 AND (i=0 OR dom_rst_n[i-1]=1 OR ch_en[i-1]=0).
REQ-030 SHALL raise dom_rst_n[i] after the release condition has held continuously for RELEASE_GAP cycles; a condition drop restarts the count.
REQ-031 SHALL drive dom_rst_n[i] low on the cycle after the release condition falls, so a loss on channel i cascades to higher channels one cycle per stage.
REQ-032 SHALL keep dom_rst_n[i]=0 for any disabled channel.
REQ-033 SHALL drive all_ready=1 (registered) iff at least one channel is enabled and dom_rst_n[i]=1 for every enabled channel.
REQ-034 SHALL size every counter to hold its parameter's maximum value, with no wrap.

Reset
REQ-035 SHALL, while rst_n=0 at a clk_in edge: put all FSMs in OFF; drive pll_rst all-ones; zero locked_filt, dom_rst_n, fault, loss_sticky, all_ready, all counters and the synchronizers.
REQ-036 SHALL abort the sequence when rst_n is asserted mid-sequence: the next edge yields the REQ-035 values, including any channel in LOCKED or FAULT.

Verification (NUM_CH=2, RST_CYC=4, FILTER_CYC=8, LOCK_TIMEOUT=64, MAX_RETRY=2, RELEASE_GAP=16)
REQ-037 SHALL cover bring-up: ch_en=11, lock raw tied high after pll_rst falls -> pll_rst high 4 cycles, locked_filt after 2-cycle sync + 8 filter cycles, dom_rst_n[0] 16 cycles later, dom_rst_n[1] 16 cycles after that, all_ready 1 cycle later.
REQ-038 SHALL cover glitch filtering: a 1-cycle raw low during WAIT at filter count 5 -> count restarts, locked_filt delayed accordingly.
REQ-039 SHALL cover timeout/fault: ch0 never locks -> two 64-cycle WAIT windows separated by 4-cycle pll_rst pulses, then fault[0]=1 and pll_rst[0] held 1; fault_clr[0] pulse -> RST restarts.
REQ-040 SHALL cover lock loss: with both channels released, ch0 raw drops 1 cycle -> loss_sticky[0]=1; dom_rst_n[0] falls; dom_rst_n[1] falls 1 cycle later; all_ready=0; re-lock and re-release follow.
REQ-041 SHALL cover disable bypass: ch_en=10, ch1 locked -> dom_rst_n[1] rises 16 cycles after lock, with no dependency on ch0; all_ready=1.
REQ-042 SHALL cover mid-sequence reset: rst_n=0 for 1 cycle while ch0 is in LOCKED -> the REQ-035 values on the next edge, and the full bring-up repeats.
